// File: rtl/spwm_sequencer.sv
// spwm_sequencer: run/stop sequencer, phase stepping and amplitude ramp for sine PWM.
// Optional: define SPWM_PHASE_RESET_EN to restart every burst at theta=0.
module spwm_sequencer #(
    parameter int ACC_W    = 16,
    parameter int RAMP_DIV = 4,
    parameter int DUTY_MID = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [ACC_W-1:0] freq_word,
    input  logic [7:0]       amp_target,
    input  logic             period_end,
    input  logic [7:0]       sin_duty,
    output logic [7:0]       theta,
    output logic [7:0]       duty_out,
    output logic             duty_load,
    output logic             busy,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [7:0] MID = 8'(DUTY_MID);

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [7:0]        amp;
    logic [7:0]        amp_step;
    logic [CNT_W-1:0]  ramp_cnt;
    logic              step_en;
    logic signed [8:0] s_val;
    logic signed [8:0] a_val;
    logic signed [17:0] prod;
    logic [15:0]       scaled;
    logic [7:0]        duty_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !stop) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (stop) state_nxt = RAMP_DOWN;
                else if (amp == amp_target) state_nxt = RUN;
            end
            RUN: begin
                if (stop) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (start && !stop) state_nxt = RAMP_UP;
                else if (amp == 8'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        state_o = state;
    end

    // Fixed-point MID*256 + s*amp; the upper byte is MID + floor(s*amp/256)
    always_comb begin
        s_val    = $signed({1'b0, sin_duty}) - 9'sd128;
        a_val    = $signed({1'b0, amp});
        prod     = s_val * a_val;
        scaled   = {MID, 8'h00} + prod[15:0];
        duty_nxt = scaled[15:8];
    end

    always_comb begin
        amp_step = amp;
        unique case (state)
            RAMP_UP, RUN: begin
                if (amp < amp_target) amp_step = amp + 8'd1;
                else if (amp > amp_target) amp_step = amp - 8'd1;
            end
            RAMP_DOWN: begin
                if (amp != 8'd0) amp_step = amp - 8'd1;
            end
            default: amp_step = 8'd0;
        endcase
    end

    always_comb begin
        step_en = period_end && (ramp_cnt == CNT_LAST);
        acc_nxt = acc;
        if (period_end && (state != IDLE)) acc_nxt = acc + freq_word;
`ifdef SPWM_PHASE_RESET_EN
        if ((state == IDLE) && (state_nxt == RAMP_UP)) acc_nxt = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            amp       <= 8'd0;
            ramp_cnt  <= '0;
            duty_out  <= MID;
            duty_load <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            duty_load <= period_end;
            if (period_end) begin
                duty_out <= duty_nxt;
                ramp_cnt <= (ramp_cnt == CNT_LAST) ? '0 : ramp_cnt + CNT_W'(1);
                if (step_en) amp <= amp_step;
            end
        end
    end

    assign theta = acc[ACC_W-1 -: 8];

endmodule

// File: doc/spwm_sequencer.md
Name: spwm_sequencer

Overview:
- Run/stop sequencer for the sine-PWM datapath.
- Phase stepping: owns the phase accumulator that drives the sine lookup's theta input.
- Amplitude control: scales the lookup's duty output by a ramped amplitude (soft start/stop).
- Duty loading: issues one registered duty word per PWM carrier period to the PWM generator, so duty never changes mid-period.

Parameters:
- ACC_W, 16: phase accumulator width; theta = acc[ACC_W-1:ACC_W-8]; legal range 8..24.
- RAMP_DIV, 4: carrier periods per ±1 amplitude step; legal range ≥1.
- DUTY_MID, 128: duty value meaning zero output (50%).

Ports:
- clk  in  1  system clock (same clock as the PWM generator).
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; request run.
- stop  in  1  level; request ramp-down; overrides start.
- freq_word  in  ACC_W  phase increment per carrier period; sampled at each period_end.
- amp_target  in  8  target amplitude, 0..255; 255 ≈ full scale.
- period_end  in  1  one-cycle strobe from the PWM generator at carrier wrap.
- sin_duty  in  8  combinational duty from the sine lookup for the current theta.
- theta  out  8  phase to the sine lookup.
- duty_out  out  8  registered scaled duty to the PWM generator.
- duty_load  out  1  one-cycle strobe; duty_out valid, latch it now.
- busy  out  1  high in any state other than IDLE.
- state_o  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, acc=0, theta=0, amp=0, ramp_cnt=0.
  - duty_out=DUTY_MID, duty_load=0, busy=0.
  - Takes effect from any state, mid-ramp included. No partial duty_load after reset.
- Scaling, computed each period_end:
  - s = sin_duty − 128 (9-bit signed).
  - p = s × amp (17-bit signed).
  - duty_next = DUTY_MID + (p >>> 8), arithmetic shift (floor).
  - Result range is 0..254; no saturation logic is needed. Must match exactly.
- Period event (period_end=1, rst=0):
  - duty_out <= duty_next, using pre-increment theta and current amp.
  - duty_load=1 on the following cycle (1-cycle latency).
  - If state≠IDLE: acc <= acc + freq_word, wrapping modulo 2^ACC_W.
  - Ramp counter: ramp_cnt increments; when it reaches RAMP_DIV−1 it clears, and an amplitude step is allowed this event.
- Amplitude step (only on an allowed event):
  - RAMP_UP and RUN: amp moves 1 toward amp_target (up or down).
  - RAMP_DOWN: amp decrements toward 0.
  - IDLE: amp holds at 0.
- State transitions, evaluated every cycle:
  - IDLE: start & !stop → RAMP_UP.
  - RAMP_UP:
    - stop → RAMP_DOWN.
    - amp == amp_target → RUN. Includes amp_target=0: one cycle in RAMP_UP, then RUN.
  - RUN:
    - stop → RAMP_DOWN.
    - amp continues tracking amp_target changes at the ramp rate.
  - RAMP_DOWN:
    - start & !stop → RAMP_UP; amp continues from its current value.
    - else amp == 0 → IDLE.
- Idle output: in IDLE, amp=0, so duty_out = DUTY_MID at every period_end; duty_load still pulses.
- theta: always acc[ACC_W-1:ACC_W-8], registered. It holds its value in IDLE.
- Simultaneous start & stop: stop wins in every state.
- A period_end in the same cycle as a state change uses the pre-transition state for the acc/amp update.

Optional Feature:
- Macro: SPWM_PHASE_RESET_EN.
- Defined: on the IDLE→RAMP_UP transition, acc clears to 0, so every burst starts at theta=0.
- Undefined: acc is retained across stop/start, and phase continues from where it stopped.

Test Plan:
- Reset mid-RUN (amp=200) → next cycle: state_o=0, theta=0, duty_out=128, busy=0, no duty_load.
- Soft start: RAMP_DIV=4, amp_target=3, freq_word=0x0100, start=1, period_end every 10 cycles.
  - theta increments by 1 per period_end.
  - amp reaches 3 after 12 period_ends; state_o=2 on the next cycle.
  - Each duty_load arrives 1 cycle after its period_end.
- Scaling corners (amp=255):
  - sin_duty=0 → duty_out=0.
  - sin_duty=255 → duty_out=254.
  - sin_duty=128 → duty_out=128.
  - amp=128, sin_duty=192 → duty_out=160.
- Wrap: acc=0xFF80, freq_word=0x0100 → acc=0x0080 and theta=0x00 after one period_end.
- Stop priority: in RAMP_UP at amp=2, assert start=stop=1.
  - state_o=3 next cycle; amp reaches 0 after 8 period_ends, then IDLE.
  - Release stop with start held during RAMP_DOWN → state_o=1.
- Restart phase: stop at theta=0x40, let the block reach IDLE, then start.
  - Without SPWM_PHASE_RESET_EN: first period_end output uses theta=0x40.
  - With the macro defined: first period_end output uses theta=0x00.
